// File: rtl/timer_share_arbiter_pkg.sv
// Shared types and constants for the countdown-timer sharing arbiter.
// Requester slot numbers match the controllers wired to the arbiter.
package timer_share_arbiter_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int VAL_W_DEF   = 4;

   localparam int REQ_ARM   = 0;
   localparam int REQ_PUMP  = 1;
   localparam int REQ_SIREN = 2;
   localparam int REQ_SPARE = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_RUN,
      ST_DONE,
      ST_RELEASE
   } state_t;

endpackage

// File: rtl/timer_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, with wrap.
// Purely combinational; the arbiter registers the result.
module rr_pick
   import timer_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int OWN_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWN_W-1:0]   ptr,
   output logic               valid,
   output logic [OWN_W-1:0]   idx
);

   logic [OWN_W:0] sum;

   // Walk downward so the closest slot to ptr is written last and wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (OWN_W + 1)'(i);
         if (sum >= (OWN_W + 1)'(NUM_REQ)) begin
            sum = sum - (OWN_W + 1)'(NUM_REQ);
         end
         if (req[sum[OWN_W-1:0]]) begin
            valid = 1'b1;
            idx   = sum[OWN_W-1:0];
         end
      end
   end

endmodule

// File: rtl/timer_share_arbiter.sv
// Shares one countdown timer between NUM_REQ requesters, round-robin,
// with a 1 Hz watchdog that recovers from a lost expiry.
module timer_share_arbiter
   import timer_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int VAL_W   = VAL_W_DEF,
   parameter int OWN_W   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*VAL_W-1:0] req_value,
   input  logic                     expired,
   input  logic                     one_hz_enable,
   output logic                     start_timer,
   output logic [VAL_W-1:0]         timer_value,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     timeout_err,
   output logic                     busy,
   output logic [OWN_W-1:0]         owner
);

   state_t           state_q;
   state_t           state_d;
   logic [OWN_W-1:0] rr_ptr_q;
   logic [OWN_W-1:0] owner_q;
   logic [VAL_W-1:0] val_q;
   logic [VAL_W:0]   wd_q;
   logic             pick_valid;
   logic [OWN_W-1:0] pick_idx;
   logic [VAL_W-1:0] slot [NUM_REQ];
   logic [NUM_REQ-1:0] owner_oh;
   logic             wd_over;
   logic             owner_req;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      assign slot[g] = req_value[g*VAL_W +: VAL_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .OWN_W   (OWN_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner_oh  = NUM_REQ'(1) << owner_q;
   assign owner_req = req[owner_q];
   // One tick of slack over the loaded delay before declaring the expiry lost.
   assign wd_over   = wd_q > ({1'b0, val_q} + (VAL_W + 1)'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (val_q == '0) state_d = ST_DONE;
            else             state_d = ST_START;
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (expired)         state_d = ST_DONE;
            else if (!owner_req) state_d = ST_RELEASE;
            else if (wd_over)    state_d = ST_RELEASE;
         end
         ST_DONE:    state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         owner_q  <= '0;
         val_q    <= '0;
         wd_q     <= '0;
      end else begin
         if (state_q == ST_IDLE && pick_valid) begin
            owner_q <= pick_idx;
            val_q   <= slot[pick_idx];
         end
         if (state_q == ST_START) begin
            wd_q <= '0;
         end else if (state_q == ST_RUN && one_hz_enable && wd_q != '1) begin
            wd_q <= wd_q + (VAL_W + 1)'(1);
         end
         if (state_q == ST_RELEASE) begin
            if (owner_q == OWN_W'(NUM_REQ - 1)) rr_ptr_q <= '0;
            else rr_ptr_q <= owner_q + OWN_W'(1);
         end
      end
   end

   always_comb begin
      start_timer = 1'b0;
      grant       = '0;
      done        = '0;
      timeout_err = 1'b0;
      busy        = (state_q != ST_IDLE);
      timer_value = val_q;
      owner       = owner_q;
      case (state_q)
         ST_LOAD:  grant = owner_oh;
         ST_START: begin
            grant       = owner_oh;
            start_timer = 1'b1;
         end
         ST_RUN: begin
            grant       = owner_oh;
            timeout_err = !expired && owner_req && wd_over;
         end
         ST_DONE: begin
            grant = owner_oh;
            done  = owner_oh;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Directed bench for timer_share_arbiter with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_timer_share_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] req_value = '0;
   logic        expired = 1'b0;
   logic        one_hz_enable = 1'b0;
   logic        start_timer;
   logic [3:0]  timer_value;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        timeout_err;
   logic        busy;
   logic [1:0]  owner;

   int n_tests = 0;
   int n_fail  = 0;

   timer_share_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .req_value     (req_value),
      .expired       (expired),
      .one_hz_enable (one_hz_enable),
      .start_timer   (start_timer),
      .timer_value   (timer_value),
      .grant         (grant),
      .done          (done),
      .timeout_err   (timeout_err),
      .busy          (busy),
      .owner         (owner)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_val(input int i, input logic [3:0] v);
      req_value[i*4 +: 4] = v;
   endtask

   task automatic hz_pulse();
      one_hz_enable = 1'b1;
      tick();
      one_hz_enable = 1'b0;
      tick();
   endtask

   task automatic serve(input int idx);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (grant == '0 && n < 8);
      check("rr_grant", 32'(grant), 32'(1) << idx);
      check("rr_no_start_in_load", 32'(start_timer), 0);
      tick();
      check("rr_start", 32'(start_timer), 1);
      tick();
      check("rr_run_no_start", 32'(start_timer), 0);
      expired = 1'b1;
      tick();
      expired = 1'b0;
      check("rr_done", 32'(done), 32'(1) << idx);
      tick();
      check("rr_release_grant", 32'(grant), 0);
      check("rr_release_start", 32'(start_timer), 0);
      tick();
      check("rr_idle_gap", 32'(busy), 0);
   endtask

   initial begin
      #2;
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_start", 32'(start_timer), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_done", 32'(done), 0);
      tick();
      reset = 1'b1;
      tick();

      // single request, value 3
      set_val(1, 4'd3);
      req = 4'b0010;
      tick();
      check("single_grant", 32'(grant), 32'h2);
      check("single_owner", 32'(owner), 1);
      check("single_start_c1", 32'(start_timer), 0);
      tick();
      check("single_start_c2", 32'(start_timer), 1);
      check("single_tval", 32'(timer_value), 3);
      tick();
      for (int k = 0; k < 3; k++) hz_pulse();
      check("single_no_early_done", 32'(done), 0);
      check("single_no_timeout", 32'(timeout_err), 0);
      expired = 1'b1;
      tick();
      expired = 1'b0;
      check("single_done", 32'(done), 32'h2);
      req = 4'b0000;
      tick();
      check("single_done_1cyc", 32'(done), 0);
      check("single_busy_rel", 32'(busy), 1);
      tick();
      check("single_busy_idle", 32'(busy), 0);

      // round-robin from a fresh pointer
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_val(i, 4'd1);
      req = 4'b1111;
      serve(0);
      serve(1);
      serve(2);
      serve(3);
      serve(0);
      req = 4'b0000;

      // zero value: no start, done at cycle 2 (pointer now 1)
      set_val(2, 4'd0);
      req = 4'b0100;
      tick();
      check("zero_grant", 32'(grant), 32'h4);
      check("zero_start_c1", 32'(start_timer), 0);
      tick();
      check("zero_done", 32'(done), 32'h4);
      check("zero_start_c2", 32'(start_timer), 0);
      req = 4'b0000;
      tick();
      check("zero_rel_start", 32'(start_timer), 0);
      tick();
      check("zero_idle", 32'(busy), 0);

      // cancel of requester 0, stale expiries, then requester 3
      set_val(0, 4'd5);
      req = 4'b0001;
      tick();
      check("cancel_grant0", 32'(grant), 32'h1);
      set_val(3, 4'd2);
      req = 4'b1001;
      tick();
      check("cancel_start", 32'(start_timer), 1);
      check("cancel_tval", 32'(timer_value), 5);
      tick();
      hz_pulse();
      req = 4'b1000;
      tick();
      check("cancel_no_done", 32'(done), 0);
      check("cancel_rel_grant", 32'(grant), 0);
      tick();
      check("cancel_idle", 32'(busy), 0);
      expired = 1'b1;
      tick();
      expired = 1'b0;
      check("cancel_stale_done", 32'(done), 0);
      check("next_grant3", 32'(grant), 32'h8);
      check("next_tval", 32'(timer_value), 2);
      tick();
      check("next_fresh_start", 32'(start_timer), 1);
      expired = 1'b1;
      tick();
      expired = 1'b0;
      check("start_stale_done", 32'(done), 0);
      check("start_stale_busy", 32'(busy), 1);
      tick();
      check("start_stale_grant", 32'(grant), 32'h8);
      expired = 1'b1;
      req = 4'b0000;
      tick();
      expired = 1'b0;
      check("simul_done", 32'(done), 32'h8);
      tick();
      tick();
      check("simul_idle", 32'(busy), 0);

      // watchdog: value 2, expiry never comes (pointer now 0)
      set_val(1, 4'd2);
      req = 4'b0010;
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         one_hz_enable = 1'b1;
         tick();
         one_hz_enable = 1'b0;
         check($sformatf("wd_tick%0d", k + 1), 32'(timeout_err),
               (k == 3) ? 32'd1 : 32'd0);
         if (k < 3) begin
            tick();
            check("wd_gap", 32'(timeout_err), 0);
         end
      end
      tick();
      check("wd_no_done", 32'(done), 0);
      check("wd_err_1cyc", 32'(timeout_err), 0);
      check("wd_rel_grant", 32'(grant), 0);
      req = 4'b0000;
      tick();

      // asynchronous reset mid-run (pointer now 2)
      set_val(2, 4'd5);
      req = 4'b0100;
      tick();
      tick();
      tick();
      check("ar_busy_before", 32'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("ar_grant", 32'(grant), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_start", 32'(start_timer), 0);
      check("ar_owner", 32'(owner), 0);
      check("ar_tval", 32'(timer_value), 0);
      check("ar_done", 32'(done), 0);
      set_val(1, 4'd7);
      set_val(3, 4'd9);
      req = 4'b1010;
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("ar_regrant", 32'(grant), 32'h2);
      check("ar_reowner", 32'(owner), 1);
      check("ar_retval", 32'(timer_value), 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
